lcd_cmd_seq: RTL and testbench
==============================

// Module: lcd_cmd_seq
// PURPOSE
//  Command sequencer directly upstream of the LCD image controller. Buffers 4-bit host
//  commands in a FIFO and issues them one at a time on cmd/cmd_valid, honouring the
//  controller's busy/done handshake. After the Write command (0) completes (done=1) it
//  halts and reports seq_done. Decouples bursty host command streams from controller latency.
// PARAMETERS
//  DEPTH  8  FIFO entries (power of 2, >=2)
//  AW     3  log2(DEPTH)
//  GUARD  2  cycles after a cmd_valid pulse before busy is trusted (1..7)
// PORTS
//  clk          in   1     clock, rising edge
//  reset        in   1     asynchronous, active-high
//  host_cmd     in   4     command code from host
//  host_valid   in   1     host_cmd valid
//  host_ready   out  1     FIFO can accept; transfer when host_valid&&host_ready
//  cmd          out  4     command to LCD controller
//  cmd_valid    out  1     one-cycle issue strobe
//  busy         in   1     controller busy
//  done         in   1     controller finished image write-back
//  seq_done     out  1     sticky: Write completed, sequencer halted
//  fifo_level   out  AW+1  current FIFO occupancy 0..DEPTH
//  err_illegal  out  1     one-cycle pulse: illegal code dropped (LCD_CMD_SEQ_FILTER_EN only)
// BEHAVIOUR
//  Reset: reset is asynchronous, active-high; clock is clk. All outputs 0 except host_ready=1; FIFO empty; state BOOT.
//  Reset mid-operation discards FIFO contents and any in-flight command; no cmd_valid for reset's duration.
//  FIFO: push on host_valid&&host_ready; host_ready=0 when level==DEPTH or state==HALT.
//   Simultaneous push+pop at full or empty is legal; level unchanged when both occur.
//   Pointers wrap modulo DEPTH; level is registered, updated same edge as push/pop.
//  FSM (registered):
//   BOOT: controller loads image after reset; wait until busy==0 -> IDLE.
//   IDLE: if FIFO non-empty && busy==0 -> ISSUE.
//   ISSUE: pop head; cmd<=head, cmd_valid<=1 for exactly one cycle; guard counter<=GUARD -> WAIT.
//   WAIT: decrement guard; when guard==0 && busy==0: head was Write(0) -> DRAIN, else -> IDLE.
//   DRAIN: wait done==1 -> HALT (seq_done<=1 same edge).
//   HALT: terminal until reset; cmd_valid=0, host_ready=0, FIFO frozen (level holds).
//  cmd holds last issued code between strobes; latency push->cmd_valid = 2 cycles min when idle.
//  Never two cmd_valid pulses less than GUARD+2 cycles apart.
//  busy rising during IDLE with FIFO non-empty: stay IDLE (issue blocked).
//  done asserted outside DRAIN: ignored.
// CONFIGURATION
//  LCD_CMD_SEQ_FILTER_EN defined: codes 13..15 at FIFO head are popped in ISSUE without
//   cmd_valid, err_illegal pulses 1 cycle, FSM returns to IDLE.
//  Undefined: all codes forwarded verbatim; err_illegal tied 0.
// STRUCTURE
//  Package lcd_pkg: cmd code localparams (WRITE=0 .. LOAD=12, codes 13..15 illegal),
//   seq state enum {BOOT,IDLE,ISSUE,WAIT,DRAIN,HALT}, 4-bit cmd_t typedef.
//  One sub-module: lcd_cmd_fifo (DEPTH x 4 sync FIFO, push/pop/level/full/empty).
//  FSM, guard counter, outputs live in lcd_cmd_seq top.
// TESTING
//  1 Reset, busy=1 for 64 cycles then 0, push 3 (ShiftLeft) -> single cmd_valid with cmd=3 after busy low.
//  2 Push 9 cmds back-to-back, DEPTH=8 -> host_ready=0 at level 8; 9th accepted after first pop; order preserved.
//  3 Push 5,7,0; busy pulses 2 cycles per cmd; done at 70 cycles after Write -> seq_done=1, host_ready=0.
//  4 Push 14 with FILTER_EN -> no cmd_valid, err_illegal=1 for 1 cycle, level 1->0; without -> cmd=14 issued.
//  5 Assert reset during DRAIN with 3 entries queued -> level=0, seq_done=0, state BOOT, no cmd_valid.
//  6 Simultaneous push and pop at level 8 -> level stays 8, no entry lost or duplicated.

Source files
------------

// File: rtl/lcd_cmd_seq_pkg.sv
// Shared types for the LCD command sequencer: command codes, sequencer state, command type.
// Codes above CMD_LOAD are illegal and are only acted upon when LCD_CMD_SEQ_FILTER_EN is defined.
package lcd_pkg;

  typedef logic [3:0] cmd_t;

  localparam cmd_t CMD_WRITE = 4'd0;
  localparam cmd_t CMD_LOAD  = 4'd12;

  typedef enum logic [2:0] {
    ST_BOOT,
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_DRAIN,
    ST_HALT
  } seq_state_t;

  function automatic logic is_illegal(cmd_t code);
    return code > CMD_LOAD;
  endfunction

endpackage

// File: rtl/lcd_cmd_seq_if.sv
// Host-side and controller-side signals of the command sequencer.
// master = the surrounding environment (host + LCD controller), slave = the sequencer.
interface lcd_cmd_seq_if #(parameter int AW = 3);
  import lcd_pkg::*;

  cmd_t        host_cmd;
  logic        host_valid;
  logic        host_ready;
  cmd_t        cmd;
  logic        cmd_valid;
  logic        busy;
  logic        done;
  logic        seq_done;
  logic [AW:0] fifo_level;
  logic        err_illegal;

  modport master (
    output host_cmd, host_valid, busy, done,
    input  host_ready, cmd, cmd_valid, seq_done, fifo_level, err_illegal
  );

  modport slave (
    input  host_cmd, host_valid, busy, done,
    output host_ready, cmd, cmd_valid, seq_done, fifo_level, err_illegal
  );

endinterface

// File: rtl/lcd_cmd_seq_fifo.sv
// DEPTH x 4-bit synchronous FIFO with registered occupancy; head is read combinationally.
// A push while full is accepted only together with a pop (the freed slot is reused).
module lcd_cmd_fifo
  import lcd_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        push,
  input  logic        pop,
  input  cmd_t        wdata,
  output cmd_t        rdata,
  output logic [AW:0] level,
  output logic        full,
  output logic        empty
);

  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

  cmd_t          mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (level == FULL_LVL);
  assign empty   = (level == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rptr];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= wdata;
  end

endmodule

// File: rtl/lcd_cmd_seq.sv
// LCD command sequencer: queues host commands and issues them one at a time to the controller,
// halting after Write completes. Optional build macro LCD_CMD_SEQ_FILTER_EN drops codes 13..15.
module lcd_cmd_seq
  import lcd_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int AW    = 3,
  parameter int GUARD = 2
) (
  input  logic            clk,
  input  logic            reset,
  lcd_cmd_seq_if.slave    bus
);

  seq_state_t state;
  seq_state_t state_nxt;
  cmd_t       head;
  logic       full;
  logic       empty;
  logic       pop;
  logic       push;
  logic       ready;
  logic       drop;
  logic       head_write;
  logic [2:0] guard;
  logic       err_q;

  assign pop  = (state == ST_ISSUE);
  // The slot freed by this cycle's pop may be refilled in the same cycle.
  assign ready = (state != ST_HALT) && (!full || pop);
  assign push  = bus.host_valid && ready;
  assign bus.host_ready = ready;

`ifdef LCD_CMD_SEQ_FILTER_EN
  assign drop = pop && is_illegal(head);
`else
  assign drop = 1'b0;
`endif

  assign bus.err_illegal = err_q;

  lcd_cmd_fifo #(.DEPTH(DEPTH), .AW(AW)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .wdata (bus.host_cmd),
    .rdata (head),
    .level (bus.fifo_level),
    .full  (full),
    .empty (empty)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_BOOT;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_BOOT:  if (!bus.busy) state_nxt = ST_IDLE;
      ST_IDLE:  if (!empty && !bus.busy) state_nxt = ST_ISSUE;
      ST_ISSUE: state_nxt = drop ? ST_IDLE : ST_WAIT;
      ST_WAIT:  if (guard == 3'd0 && !bus.busy) state_nxt = head_write ? ST_DRAIN : ST_IDLE;
      ST_DRAIN: if (bus.done) state_nxt = ST_HALT;
      ST_HALT:  state_nxt = ST_HALT;
      default:  state_nxt = ST_BOOT;
    endcase
  end

  // busy is not trusted until the guard count has run out after each strobe.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.cmd       <= '0;
      bus.cmd_valid <= 1'b0;
      bus.seq_done  <= 1'b0;
      err_q         <= 1'b0;
      head_write    <= 1'b0;
      guard         <= '0;
    end else begin
      bus.cmd_valid <= pop && !drop;
      err_q         <= drop;
      if (pop && !drop) begin
        bus.cmd    <= head;
        head_write <= (head == CMD_WRITE);
        guard      <= 3'(GUARD);
      end else if (state == ST_WAIT && guard != 3'd0) begin
        guard <= guard - 3'd1;
      end
      if (state == ST_DRAIN && bus.done) bus.seq_done <= 1'b1;
    end
  end

endmodule

// File: tb/tb_lcd_cmd_seq.sv
// Randomized bench for lcd_cmd_seq against a queue-based model of the sequencer's observable rules.
module tb_lcd_cmd_seq;
  import lcd_pkg::*;

  localparam int DEPTH = 8;
  localparam int AW    = 3;
  localparam int GUARD = 2;
`ifdef LCD_CMD_SEQ_FILTER_EN
  localparam bit FILT = 1'b1;
`else
  localparam bit FILT = 1'b0;
`endif

  typedef struct {
    logic [3:0] code;
    int         cyc;
  } ent_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  lcd_cmd_seq_if #(.AW(AW)) bus ();

  lcd_cmd_seq #(.DEPTH(DEPTH), .AW(AW), .GUARD(GUARD)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  ent_t       q[$];
  int         nvec = 0, nerr = 0, cyc = 0;
  int         last_strobe = -1000, strobes = 0, errs = 0;
  int         busy_len = 0, busy_cnt = 0;
  logic [3:0] last_cmd = 4'd0, drv_cmd = 4'd0;
  logic       drv_valid = 1'b0, drv_done = 1'b0, busy_force = 1'b0, acc = 1'b0;
  logic       busy_d1 = 1'b0, busy_d2 = 1'b0;
  bit         write_seen = 1'b0, exp_seq = 1'b0, seq_pending = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    if (obs !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // One clock: check outputs against the model, then drive inputs for the next edge.
  task automatic step();
    ent_t e;
    @(negedge clk);
    cyc++;
    if (seq_pending) begin exp_seq = 1'b1; seq_pending = 1'b0; end
    if (bus.cmd_valid === 1'b1) begin
      strobes++;
      check("strobe_nonempty", q.size() > 0, 1);
      if (q.size() > 0) begin
        e = q.pop_front();
        check("order", bus.cmd, e.code);
        check("latency", (cyc - e.cyc) >= 3, 1);
        if (FILT) check("illegal_issued", e.code > 4'd12, 0);
        last_cmd = e.code;
        if (e.code == 4'd0) write_seen = 1'b1;
      end
      check("spacing", (cyc - last_strobe) >= GUARD + 2, 1);
      check("busy_block", busy_d2, 0);
      check("halt_issue", exp_seq, 0);
      last_strobe = cyc;
      busy_cnt = busy_len;
    end
    if (FILT) begin
      if (bus.err_illegal === 1'b1) begin
        errs++;
        check("err_nonempty", q.size() > 0, 1);
        if (q.size() > 0) begin
          e = q.pop_front();
          check("err_code", e.code > 4'd12, 1);
        end
      end
    end else begin
      check("err_tied", bus.err_illegal, 0);
    end
    check("level", bus.fifo_level, q.size());
    check("cmd_hold", bus.cmd, last_cmd);
    check("seq_done", bus.seq_done, exp_seq);
    if (exp_seq) check("ready_halt", bus.host_ready, 0);
    else if (q.size() < DEPTH) check("ready", bus.host_ready, 1);
    busy_d2 = busy_d1;
    bus.busy = busy_force || (busy_cnt > 0);
    if (busy_cnt > 0) busy_cnt--;
    busy_d1 = bus.busy;
    bus.done = drv_done;
    if (drv_done && write_seen) seq_pending = 1'b1;
    bus.host_valid = drv_valid;
    bus.host_cmd   = drv_cmd;
    #1;
    acc = bus.host_valid && bus.host_ready;
    if (acc) q.push_back('{drv_cmd, cyc});
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    drv_valid = 1'b0; drv_done = 1'b0;
    bus.host_valid = 1'b0; bus.done = 1'b0; bus.busy = busy_force;
    q.delete();
    last_cmd = 4'd0; exp_seq = 1'b0; seq_pending = 1'b0; write_seen = 1'b0;
    busy_cnt = 0; last_strobe = -1000; busy_d1 = 1'b0; busy_d2 = 1'b0; acc = 1'b0;
    #1;
    check("rst_valid", bus.cmd_valid, 0);
    check("rst_level", bus.fifo_level, 0);
    check("rst_seq", bus.seq_done, 0);
    check("rst_ready", bus.host_ready, 1);
    check("rst_err", bus.err_illegal, 0);
    check("rst_cmd", bus.cmd, 0);
    repeat (3) @(negedge clk);
    check("rst_hold_valid", bus.cmd_valid, 0);
    reset = 1'b0;
  endtask

  task automatic push_list(input logic [3:0] c0, c1, c2, c3, input int n);
    for (int k = 0; k < n; k++) begin
      drv_cmd = (k == 0) ? c0 : (k == 1) ? c1 : (k == 2) ? c2 : c3;
      drv_valid = 1'b1;
      for (int t = 0; t < 30; t++) begin
        step();
        if (acc) break;
      end
      check("push_timeout", acc, 1);
    end
    drv_valid = 1'b0;
  endtask

  task automatic drain();
    for (int t = 0; t < 400 && (q.size() > 0 || busy_cnt > 0); t++) step();
    check("drain_timeout", q.size(), 0);
    repeat (8) step();
  endtask

  task automatic wait_write();
    for (int t = 0; t < 100 && !write_seen; t++) step();
    check("write_timeout", write_seen, 1);
  endtask

  initial begin
    int s0;
    int n;
    bus.host_cmd = 4'd0; bus.host_valid = 1'b0; bus.busy = 1'b1; bus.done = 1'b0;
    busy_force = 1'b1;
    do_reset();

    // Boot: controller busy for 64 cycles, one ShiftLeft queued meanwhile.
    busy_len = 1;
    for (int i = 0; i < 64; i++) begin
      drv_valid = (i == 5); drv_cmd = 4'd3;
      step();
    end
    drv_valid = 1'b0;
    check("boot_block", strobes, 0);
    busy_force = 1'b0;
    for (int t = 0; t < 20 && strobes == 0; t++) step();
    check("first_strobe", strobes, 1);
    check("first_cmd", last_cmd, 3);
    repeat (10) step();

    // Illegal code 14: dropped with err_illegal when filtering, forwarded otherwise.
    s0 = errs;
    push_list(4'd14, 4'd0, 4'd0, 4'd0, 1);
    drain();
    if (FILT) check("filter_err", errs - s0, 1);
    else      check("fwd_14", last_cmd, 14);

    // Fill to DEPTH while the controller is busy, then push into the pop cycle.
    busy_force = 1'b1;
    repeat (3) step();
    n = 0;
    for (int t = 0; t < 40 && n < DEPTH; t++) begin
      drv_cmd = 4'(n + 1); drv_valid = 1'b1;
      step();
      if (acc) n++;
    end
    drv_cmd = 4'd9;
    step();
    check("full_level", bus.fifo_level, DEPTH);
    check("full_ready", bus.host_ready, 0);
    busy_force = 1'b0;
    for (int t = 0; t < 10 && !acc; t++) step();
    check("push_at_full", acc, 1);
    drv_valid = 1'b0;
    step();
    check("pushpop_level", bus.fifo_level, DEPTH);
    check("pushpop_strobe", bus.cmd_valid, 1);
    drain();

    // Random traffic: no Write, random busy lengths, stray done pulses.
    for (int i = 0; i < 800; i++) begin
      drv_valid  = ($urandom_range(0, 9) < 6);
      drv_cmd    = 4'($urandom_range(1, 15));
      busy_len   = $urandom_range(0, 3);
      busy_force = ($urandom_range(0, 19) == 0);
      drv_done   = ($urandom_range(0, 15) == 0);
      step();
    end
    drv_valid = 1'b0; drv_done = 1'b0; busy_force = 1'b0; busy_len = 1;
    drain();
    check("stray_done", bus.seq_done, 0);

    // Reset while draining a Write with three entries still queued.
    push_list(4'd0, 4'd4, 4'd6, 4'd8, 4);
    wait_write();
    s0 = strobes;
    repeat (8) step();
    check("drain_level", bus.fifo_level, 3);
    check("drain_block", strobes, s0);
    do_reset();
    step();

    // 5, 7, Write with 2-cycle busy; done 70 cycles after Write.
    busy_len = 2;
    push_list(4'd5, 4'd7, 4'd0, 4'd0, 3);
    wait_write();
    s0 = strobes;
    repeat (70) step();
    check("pre_done_seq", bus.seq_done, 0);
    drv_done = 1'b1;
    step();
    drv_done = 1'b0;
    step();
    check("final_seq_done", bus.seq_done, 1);
    check("halt_ready", bus.host_ready, 0);
    drv_valid = 1'b1; drv_cmd = 4'd6;
    repeat (5) step();
    drv_valid = 1'b0;
    check("halt_level", bus.fifo_level, 0);
    check("halt_strobes", strobes, s0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
